inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction-fetch front end for the RISC-V pipeline. It owns the PC and reads each 32-bit instruction as four bytes over the shared byte-wide memory port, granted by the memory arbiter. It presents the assembled instruction to the IF/ID register and takes the redirect (`branch_flag`/`branch_target_address`) and stall signals driven back by decode and ctrl. It is the producer end of the instruction/redirect interface that the decode stage consumes.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC after reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `stall_i`  in  1  pipeline stall from ctrl. While high, the held instruction is not consumed and redirects are ignored.
- `branch_flag_i`  in  1  redirect request from decode.
- `branch_target_address_i`  in  32  redirect PC.
- `mem_req_o`  out  1  byte read request.
- `mem_addr_o`  out  32  byte address of the request.
- `mem_gnt_i`  in  1  arbiter grant, sampled in the same cycle as `mem_req_o`.
- `mem_din_i`  in  8  read data. It is valid in the cycle after a granted request.
- `pc_o`  out  32  PC of `inst_o`.
- `inst_o`  out  32  assembled instruction, little-endian.
- `inst_valid_o`  out  1  `inst_o`/`pc_o` hold a complete instruction.

## Operation
- **State:** `pc` register, issue counter `iss` (0..4), capture counter `cap` (0..4), byte buffer, `pend` flag (a granted byte is in flight), and a two-state FSM.
- **FETCH state:**
  - `mem_req_o = (iss < 4) && !rst`.
  - `mem_addr_o = pc + iss`, modulo 2^32.
  - A cycle with `mem_req_o & mem_gnt_i` increments `iss` and sets `pend` for the next cycle.
  - Any cycle with `pend` high stores `mem_din_i` as byte `cap` and increments `cap`.
  - When the fourth byte is captured, `inst_o` is loaded with {b3,b2,b1,b0}, `pc_o` is loaded with `pc`, `inst_valid_o` is set, and the FSM moves to HOLD.
- **HOLD state:**
  - `mem_req_o = 0`.
  - `inst_o`, `pc_o` and `inst_valid_o = 1` are held stable while `stall_i` is high.
  - Consumption happens at an edge with `stall_i = 0`. Next cycle: `inst_valid_o = 0`, `pc` ← `pc + 4`, counters cleared, FSM → FETCH.
- **Redirect:** occurs at an edge with `branch_flag_i = 1` and `stall_i = 0`, in either state.
  - `pc` ← `branch_target_address_i`, counters cleared, `inst_valid_o` ← 0, FSM → FETCH.
  - A byte still in flight, returning in the following cycle, is discarded.
  - Redirect has priority over consumption. A held instruction that would have been consumed on that edge is dropped.
- **Stall and redirect together:** `branch_flag_i` is ignored while `stall_i = 1`. Fetch byte traffic in FETCH continues regardless of `stall_i`.
- **Address handling:** no alignment check is made on the target. The address wraps modulo 2^32, so `pc` = FFFF_FFFE fetches FFFF_FFFE, FFFF_FFFF, 0000_0000, 0000_0001.
- **Reset values:** `inst_valid_o` = 0, `inst_o` = 0, `pc_o` = `RESET_PC`, `mem_req_o` = 0 (also forced low combinationally while `rst` is high), `mem_addr_o` = `RESET_PC`. Internal `pc` = `RESET_PC`, counters 0, FSM = FETCH.
- **Reset mid-fetch:** all partial state is discarded. The in-flight byte is ignored.

## Timing
- **Fetch latency:** the first cycle with `rst` low is cycle c. With grant held high:
  - requests in c..c+3;
  - data on `mem_din_i` in c+1..c+4;
  - `inst_valid_o` = 1 from c+5.
- **Grant-low cycles:** each cycle with `mem_gnt_i` low adds one cycle of latency. `mem_addr_o` holds until granted.
- **Throughput:** back-to-back with no stall, one instruction every 6 cycles. There is 1 cycle of `inst_valid_o` high, then the 5-cycle refetch.
- **Redirect:** a redirect at edge e makes `mem_addr_o` = target in cycle e+1, with `inst_valid_o` = 0 in that cycle.
- **Outputs:** `inst_o`/`pc_o` change only on the edge that sets `inst_valid_o`. They are don't-care while `inst_valid_o` = 0.

## Test plan
- **Reset and first fetch:** `RESET_PC` = 0, memory holds bytes 13,05,10,00 at 0..3, grant held high. Expect `mem_addr_o` 0,1,2,3 in c..c+3, then `inst_o` = 0x00100513, `pc_o` = 0, `inst_valid_o` = 1 at c+5.
- **Grant gaps:** deassert `mem_gnt_i` during the cycles when bytes 1 and 3 are requested. Expect `mem_addr_o` held at 1 and 3 for the extra cycles, same `inst_o`, `inst_valid_o` at c+7.
- **Stall hold and consume:** assert `stall_i` for 3 cycles while `inst_valid_o` = 1. Expect outputs unchanged and `mem_req_o` = 0. Release `stall_i`: expect `inst_valid_o` = 0 the next cycle and `mem_addr_o` = 4.
- **Redirect mid-fetch:** pulse `branch_flag_i` with target 0x100 after two bytes of pc 4 have been granted. Expect the in-flight byte ignored, `mem_addr_o` = 0x100 the next cycle, and `pc_o` = 0x100 on the following valid.
- **Redirect under stall, and redirect over consume:**
  - `branch_flag_i` with `stall_i` = 1: expect no effect.
  - `branch_flag_i` in HOLD with `stall_i` = 0: expect the held instruction dropped and the next valid at the target.
- **Wrap and reset mid-fetch:** redirect to 0xFFFFFFFE, expect addresses FFFFFFFE, FFFFFFFF, 0, 1. Assert `rst` after byte 2: expect `mem_req_o` = 0 while `rst` is high, then a fresh fetch from `RESET_PC`.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: owns the PC and assembles each 32-bit instruction from four
// byte reads over the shared memory port, then holds it for decode until it is consumed.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic [7:0]  mem_din_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  typedef enum logic [0:0] {StFetch, StHold} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [2:0]  iss_q;
  logic [2:0]  cap_q;
  logic [23:0] byte_buf_q;
  logic        pend_q;
  logic        redirect;
  logic        grant;

  always_comb begin
    mem_req_o  = (state_q == StFetch) && (iss_q < 3'd4) && !rst;
    mem_addr_o = pc_q + {29'd0, iss_q};
    redirect   = branch_flag_i && !stall_i;
    grant      = mem_req_o && mem_gnt_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      iss_q        <= 3'd0;
      cap_q        <= 3'd0;
      byte_buf_q   <= 24'd0;
      pend_q       <= 1'b0;
      pc_o         <= RESET_PC;
      inst_o       <= 32'd0;
      inst_valid_o <= 1'b0;
    end else if (redirect) begin
      // Clearing pend_q drops any byte still returning from the old stream.
      state_q      <= StFetch;
      pc_q         <= branch_target_address_i;
      iss_q        <= 3'd0;
      cap_q        <= 3'd0;
      pend_q       <= 1'b0;
      inst_valid_o <= 1'b0;
    end else begin
      case (state_q)
        StFetch: begin
          pend_q <= grant;
          if (grant) begin
            iss_q <= iss_q + 3'd1;
          end
          if (pend_q) begin
            cap_q <= cap_q + 3'd1;
            case (cap_q[1:0])
              2'd0: byte_buf_q[7:0]   <= mem_din_i;
              2'd1: byte_buf_q[15:8]  <= mem_din_i;
              2'd2: byte_buf_q[23:16] <= mem_din_i;
              default: begin
                inst_o       <= {mem_din_i, byte_buf_q};
                pc_o         <= pc_q;
                inst_valid_o <= 1'b1;
                state_q      <= StHold;
              end
            endcase
          end
        end
        StHold: begin
          if (!stall_i) begin
            state_q      <= StFetch;
            pc_q         <= pc_q + 32'd4;
            iss_q        <= 3'd0;
            cap_q        <= 3'd0;
            pend_q       <= 1'b0;
            inst_valid_o <= 1'b0;
          end
        end
        default: state_q <= StFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed vector tables for the documented scenarios plus
// randomized traffic checked against a transaction-level reference model.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic [7:0]  mem_din_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  int n_pass = 0;
  int n_tot  = 0;

  localparam logic [31:0] W0 = 32'h0010_0513;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .stall_i                (stall_i),
    .branch_flag_i          (branch_flag_i),
    .branch_target_address_i(branch_target_address_i),
    .mem_req_o              (mem_req_o),
    .mem_addr_o             (mem_addr_o),
    .mem_gnt_i              (mem_gnt_i),
    .mem_din_i              (mem_din_i),
    .pc_o                   (pc_o),
    .inst_o                 (inst_o),
    .inst_valid_o           (inst_valid_o)
  );

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'h10;
      32'd3:   return 8'h00;
      default: return a[7:0] ^ (a[15:8] + 8'h37) ^ a[31:24];
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
  endtask

  // Memory: data for a granted request appears in the next cycle, garbage otherwise.
  always @(posedge clk) begin
    if (mem_req_o && mem_gnt_i) mem_din_i <= mem_byte(mem_addr_o);
    else                        mem_din_i <= 8'($urandom);
  end

  // Reference model: counts granted/returned bytes per instruction; the instruction value comes
  // straight from the memory contents at the fetch PC.
  logic [31:0] m_pc, m_inst, m_pco;
  int          m_n, m_ret;
  bit          m_fly, m_valid;
  bit          chk_on = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 32'd0; m_n = 0; m_ret = 0; m_fly = 1'b0; m_valid = 1'b0;
      m_inst = 32'd0; m_pco = 32'd0;
    end else if (branch_flag_i && !stall_i) begin
      m_pc = branch_target_address_i; m_n = 0; m_ret = 0; m_fly = 1'b0; m_valid = 1'b0;
    end else if (m_valid) begin
      if (!stall_i) begin
        m_valid = 1'b0; m_pc = m_pc + 32'd4; m_n = 0; m_ret = 0;
      end
    end else begin
      if (m_fly) m_ret++;
      m_fly = (m_n < 4) && mem_gnt_i;
      if (m_fly) m_n++;
      if (m_ret == 4) begin
        m_valid = 1'b1; m_inst = word_at(m_pc); m_pco = m_pc;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      bit m_req;
      #2;
      m_req = !rst && !m_valid && (m_n < 4);
      check("mdl_valid", 32'(inst_valid_o), 32'(m_valid));
      check("mdl_req", 32'(mem_req_o), 32'(m_req));
      if (m_req) check("mdl_addr", mem_addr_o, m_pc + 32'(m_n));
      if (m_valid) begin
        check("mdl_inst", inst_o, m_inst);
        check("mdl_pc", pc_o, m_pco);
      end
    end
  end

  typedef struct {
    logic        rst, gnt, stall, br;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst, e_pc;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic r, input logic g, input logic s, input logic b,
                              input logic [31:0] t, input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.rst = r; v.gnt = g; v.stall = s; v.br = b; v.tgt = t;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_inst = ei; v.e_pc = ep;
    vq.push_back(v);
  endfunction

  task automatic run_vecs(input string tag);
    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst; mem_gnt_i = vq[i].gnt; stall_i = vq[i].stall;
      branch_flag_i = vq[i].br; branch_target_address_i = vq[i].tgt;
      #1;
      check($sformatf("%s%0d_req", tag, i), 32'(mem_req_o), 32'(vq[i].e_req));
      check($sformatf("%s%0d_valid", tag, i), 32'(inst_valid_o), 32'(vq[i].e_valid));
      if (vq[i].e_req) check($sformatf("%s%0d_addr", tag, i), mem_addr_o, vq[i].e_addr);
      if (vq[i].e_valid) begin
        check($sformatf("%s%0d_inst", tag, i), inst_o, vq[i].e_inst);
        check($sformatf("%s%0d_pc", tag, i), pc_o, vq[i].e_pc);
      end
    end
    vq.delete();
  endtask

  initial begin
    rst = 1'b1; stall_i = 1'b0; branch_flag_i = 1'b0; mem_gnt_i = 1'b0;
    branch_target_address_i = 32'd0;
    repeat (2) @(posedge clk);
    chk_on = 1'b1;
    @(negedge clk); #1;
    check("rst_valid", 32'(inst_valid_o), 32'd0);
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_inst", inst_o, 32'd0);
    check("rst_pc", pc_o, 32'd0);
    check("rst_addr", mem_addr_o, 32'd0);

    // First fetch, stall hold/consume, redirect mid-fetch, stalled and over-consume redirect,
    // address wrap and reset mid-fetch.
    add(0, 1, 0, 0, 0,            1, 32'h0, 0, 0, 0);
    add(0, 1, 0, 0, 0,            1, 32'h1, 0, 0, 0);
    add(0, 1, 0, 0, 0,            1, 32'h2, 0, 0, 0);
    add(0, 1, 0, 0, 0,            1, 32'h3, 0, 0, 0);
    add(0, 1, 0, 0, 0,            0, 0,     0, 0, 0);
    add(0, 1, 1, 0, 0,            0, 0,     1, W0, 32'h0);
    add(0, 1, 1, 0, 0,            0, 0,     1, W0, 32'h0);
    add(0, 1, 1, 0, 0,            0, 0,     1, W0, 32'h0);
    add(0, 1, 0, 0, 0,            0, 0,     1, W0, 32'h0);
    add(0, 1, 0, 0, 0,            1, 32'h4, 0, 0, 0);
    add(0, 1, 0, 0, 0,            1, 32'h5, 0, 0, 0);
    add(0, 1, 0, 1, 32'h100,      1, 32'h6, 0, 0, 0);
    add(0, 1, 0, 0, 0,            1, 32'h100, 0, 0, 0);
    add(0, 1, 0, 0, 0,            1, 32'h101, 0, 0, 0);
    add(0, 1, 0, 0, 0,            1, 32'h102, 0, 0, 0);
    add(0, 1, 0, 0, 0,            1, 32'h103, 0, 0, 0);
    add(0, 1, 0, 0, 0,            0, 0,     0, 0, 0);
    add(0, 1, 1, 1, 32'h200,      0, 0,     1, word_at(32'h100), 32'h100);
    add(0, 1, 1, 0, 0,            0, 0,     1, word_at(32'h100), 32'h100);
    add(0, 1, 0, 1, 32'hFFFF_FFFE, 0, 0,    1, word_at(32'h100), 32'h100);
    add(0, 1, 0, 0, 0,            1, 32'hFFFF_FFFE, 0, 0, 0);
    add(0, 1, 0, 0, 0,            1, 32'hFFFF_FFFF, 0, 0, 0);
    add(0, 1, 0, 0, 0,            1, 32'h0, 0, 0, 0);
    add(1, 1, 0, 0, 0,            0, 0,     0, 0, 0);
    add(1, 1, 0, 0, 0,            0, 0,     0, 0, 0);
    add(0, 1, 0, 0, 0,            1, 32'h0, 0, 0, 0);
    add(0, 1, 0, 0, 0,            1, 32'h1, 0, 0, 0);
    add(0, 1, 0, 0, 0,            1, 32'h2, 0, 0, 0);
    add(0, 1, 0, 0, 0,            1, 32'h3, 0, 0, 0);
    add(0, 1, 0, 0, 0,            0, 0,     0, 0, 0);
    add(0, 1, 0, 0, 0,            0, 0,     1, W0, 32'h0);
    run_vecs("a");

    // Grant gaps on bytes 1 and 3.
    add(1, 0, 0, 0, 0,            0, 0,     0, 0, 0);
    add(0, 1, 0, 0, 0,            1, 32'h0, 0, 0, 0);
    add(0, 0, 0, 0, 0,            1, 32'h1, 0, 0, 0);
    add(0, 1, 0, 0, 0,            1, 32'h1, 0, 0, 0);
    add(0, 1, 0, 0, 0,            1, 32'h2, 0, 0, 0);
    add(0, 0, 0, 0, 0,            1, 32'h3, 0, 0, 0);
    add(0, 1, 0, 0, 0,            1, 32'h3, 0, 0, 0);
    add(0, 1, 0, 0, 0,            0, 0,     0, 0, 0);
    add(0, 1, 0, 0, 0,            0, 0,     1, W0, 32'h0);
    run_vecs("b");

    // Randomized traffic, checked only by the reference model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst           = ($urandom_range(0, 199) == 0);
      mem_gnt_i     = ($urandom_range(0, 9) < 7);
      stall_i       = ($urandom_range(0, 9) < 3);
      branch_flag_i = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0)
        branch_target_address_i = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else
        branch_target_address_i = $urandom;
    end
    @(negedge clk);
    rst = 1'b0; branch_flag_i = 1'b0; stall_i = 1'b0;
    repeat (3) @(posedge clk);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
